// File: rtl/fifo_umbral.sv
// -----------------------------------------------------------------------------
// fifo_umbral
//
// Per-lane elastic FIFO feeding the PCIe link controller. Stores DATA_WIDTH-bit
// words in a 2**ADDR_WIDTH deep register array and reports empty/full plus
// almost-empty/almost-full against thresholds programmed on umbral_LH.
//
// Ports
//   clk           : clock, all logic on rising edge
//   reset         : synchronous active-high reset (pointers, count, outputs)
//   umbral_LH     : thresholds, low half = L (almost-empty), high half = H
//   wr_en/data_in : push request and data (dropped while full)
//   rd_en         : pop request (ignored while empty)
//   data_out      : registered pop data, one cycle after rd_en
//   valid_out     : single-cycle pulse marking a new data_out word
//   empty/full    : count == 0 / count == DEPTH
//   almost_empty  : count <= L
//   almost_full   : count >= H
//   error         : sticky overflow/underflow indicator
//
// Build option
//   FIFO_ERROR_EN : when defined, error latches on wr_en while full or rd_en
//                   while empty until reset. When undefined, error is tied 0.
// -----------------------------------------------------------------------------
module fifo_umbral #(
    parameter int DATA_WIDTH   = 6,
    parameter int ADDR_WIDTH   = 3,
    parameter int UMBRALES_L_H = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [UMBRALES_L_H-1:0] umbral_LH,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    valid_out,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_empty,
    output logic                    almost_full,
    output logic                    error
);

    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int CW     = ADDR_WIDTH + 1;
    localparam int HW     = UMBRALES_L_H / 2;
    // Comparison width wide enough for both count and a threshold, so a
    // threshold above DEPTH is never truncated into a false match.
    localparam int CMP_W  = (CW > HW) ? CW : HW;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid_out;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic [HW-1:0]         w_umbral_L;
    logic [HW-1:0]         w_umbral_H;
    logic [CMP_W-1:0]      w_count_cmp;
    logic [CMP_W-1:0]      w_l_cmp;
    logic [CMP_W-1:0]      w_h_cmp;

    // Status flags come straight from the registered count.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_C);

    // Requests are qualified by the registered flags only, so a push while
    // full is dropped even if a pop happens in the same cycle.
    assign w_push = wr_en & ~w_full;
    assign w_pop  = rd_en & ~w_empty;

    assign w_umbral_L  = umbral_LH[HW-1:0];
    assign w_umbral_H  = umbral_LH[UMBRALES_L_H-1:HW];
    assign w_count_cmp = CMP_W'(r_count);
    assign w_l_cmp     = CMP_W'(w_umbral_L);
    assign w_h_cmp     = CMP_W'(w_umbral_H);

    // Storage array: not reset, stale contents are unreachable after reset
    // because the pointers and count restart at zero.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Read port: data_out holds its last value when no pop occurs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= w_pop;
            if (w_pop) begin
                r_data_out <= r_mem[r_rd_ptr];
            end
        end
    end

`ifdef FIFO_ERROR_EN
    logic r_error;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_error <= 1'b0;
        end else if ((wr_en && w_full) || (rd_en && w_empty)) begin
            r_error <= 1'b1;
        end
    end

    assign error = r_error;
`else
    assign error = 1'b0;
`endif

    assign data_out     = r_data_out;
    assign valid_out    = r_valid_out;
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_empty = (w_count_cmp <= w_l_cmp);
    assign almost_full  = (w_count_cmp >= w_h_cmp);

endmodule

// File: tb/tb_fifo_umbral.sv
module tb_fifo_umbral;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] umbral_LH;
    logic       wr_en;
    logic [5:0] data_in;
    logic       rd_en;
    logic [5:0] data_out;
    logic       valid_out;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic       error;

    int checks = 0;
    int errors = 0;

`ifdef FIFO_ERROR_EN
    localparam logic ERR_AFTER_OVF = 1'b1;
`else
    localparam logic ERR_AFTER_OVF = 1'b0;
`endif

    fifo_umbral #(
        .DATA_WIDTH  (6),
        .ADDR_WIDTH  (3),
        .UMBRALES_L_H(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .umbral_LH   (umbral_LH),
        .wr_en       (wr_en),
        .data_in     (data_in),
        .rd_en       (rd_en),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .empty       (empty),
        .full        (full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .error       (error)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Flags for an expected occupancy with L=2, H=6, DEPTH=8.
    task automatic chk_flags(input string tag, input int cnt);
        chk1({tag, "_empty"}, empty,        cnt == 0);
        chk1({tag, "_full"},  full,         cnt == 8);
        chk1({tag, "_ae"},    almost_empty, cnt <= 2);
        chk1({tag, "_af"},    almost_full,  cnt >= 6);
    endtask

    // One clock with the given requests; outputs sampled 1 time unit later.
    task automatic step(input logic w, input logic [5:0] d, input logic r);
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        umbral_LH = 8'h62;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        data_in   = 6'h00;
        @(posedge clk);
        @(posedge clk);
        #1;

        // Reset values
        chk_flags("rst", 0);
        chk1("rst_valid", valid_out, 1'b0);
        chk1("rst_error", error, 1'b0);
        chkd("rst_dout", data_out, 6'h00);

        // H=0 makes almost_full true at count 0, combinationally
        umbral_LH = 8'h02;
        #1;
        chk1("h0_af", almost_full, 1'b1);
        umbral_LH = 8'h62;
        #1;
        chk1("h6_af", almost_full, 1'b0);
        reset = 1'b0;

        // Push 0x01..0x06
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 6'(k), 1'b0);
            chk_flags($sformatf("push%0d", k), k);
            chk1($sformatf("push%0d_valid", k), valid_out, 1'b0);
        end

        // Fill to 8, then overflow with 0x3F
        step(1'b1, 6'h07, 1'b0);
        chk_flags("push7", 7);
        step(1'b1, 6'h08, 1'b0);
        chk_flags("push8", 8);
        chk1("push8_err", error, 1'b0);
        step(1'b1, 6'h3F, 1'b0);
        chk_flags("ovf", 8);
        chk1("ovf_err", error, ERR_AFTER_OVF);

        // Drain: 0x01..0x08, 0x3F must not appear
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 6'h00, 1'b1);
            chkd($sformatf("pop%0d_data", k), data_out, 6'(k));
            chk1($sformatf("pop%0d_valid", k), valid_out, 1'b1);
            chk_flags($sformatf("pop%0d", k), 8 - k);
        end

        // Idle: valid pulse ends, data holds
        step(1'b0, 6'h00, 1'b0);
        chk1("idle_valid", valid_out, 1'b0);
        chkd("idle_dout", data_out, 6'h08);

        // Underflow attempt on empty
        step(1'b0, 6'h00, 1'b1);
        chk1("unf_valid", valid_out, 1'b0);
        chkd("unf_dout", data_out, 6'h08);
        chk1("unf_err", error, ERR_AFTER_OVF);
        chk_flags("unf", 0);

        // Count 4, then 5 simultaneous push/pop across the pointer wrap
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 6'(8'h11 + k), 1'b0);
        end
        chk_flags("fill4", 4);
        step(1'b1, 6'h21, 1'b1);
        chkd("pp1_data", data_out, 6'h11);
        chk_flags("pp1", 4);
        step(1'b1, 6'h22, 1'b1);
        chkd("pp2_data", data_out, 6'h12);
        step(1'b1, 6'h23, 1'b1);
        chkd("pp3_data", data_out, 6'h13);
        step(1'b1, 6'h24, 1'b1);
        chkd("pp4_data", data_out, 6'h14);
        step(1'b1, 6'h25, 1'b1);
        chkd("pp5_data", data_out, 6'h21);
        chk1("pp5_valid", valid_out, 1'b1);
        chk_flags("pp5", 4);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 6'h00, 1'b1);
            chkd($sformatf("wrap_pop%0d", k), data_out, 6'(8'h22 + k));
        end
        chk_flags("wrap_done", 0);

        // Empty: rd_en ignored while wr_en pushes 0x15
        step(1'b1, 6'h15, 1'b1);
        chk1("ewr_valid", valid_out, 1'b0);
        chk_flags("ewr", 1);
        step(1'b0, 6'h00, 1'b1);
        chkd("ewr_pop_data", data_out, 6'h15);
        chk1("ewr_pop_valid", valid_out, 1'b1);
        chk_flags("ewr_pop", 0);

        // Count 5, then reset for one cycle with wr_en high
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 6'(8'h31 + k), 1'b0);
        end
        chk_flags("fill5", 5);
        reset = 1'b1;
        step(1'b1, 6'h3E, 1'b1);
        reset = 1'b0;
        chk_flags("mid_rst", 0);
        chk1("mid_rst_valid", valid_out, 1'b0);
        chkd("mid_rst_dout", data_out, 6'h00);
        chk1("mid_rst_err", error, 1'b0);
        step(1'b1, 6'h2A, 1'b0);
        chk_flags("post_rst_push", 1);
        step(1'b0, 6'h00, 1'b1);
        chkd("post_rst_data", data_out, 6'h2A);
        chk1("post_rst_valid", valid_out, 1'b1);
        chk_flags("post_rst_pop", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_umbral.md
# fifo_umbral

Per-lane elastic FIFO that sits behind the PCIE link control state machine. It stores DATA_WIDTH-bit words, reports empty/full to the controller, and raises almost-empty/almost-full flags against the low/high thresholds (umbral_LH) that the controller programs during its INIT state. Eight instances, one per lane, feed the controller's empty_fifo_0..7 inputs; the controller's idle/active decision depends on these flags being exact and registered.

## Interface
- DATA_WIDTH, 6, word width
- ADDR_WIDTH, 3, pointer width; depth = 2**ADDR_WIDTH (8)
- UMBRALES_L_H, 8, threshold bus width; low half = umbral_L, high half = umbral_H
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high; clears pointers, count, outputs
- umbral_LH  in  UMBRALES_L_H  thresholds; [UMBRALES_L_H/2-1:0]=L, [UMBRALES_L_H-1:UMBRALES_L_H/2]=H; held stable by controller
- wr_en  in  1  push request
- data_in  in  DATA_WIDTH  push data
- rd_en  in  1  pop request
- data_out  out  DATA_WIDTH  registered pop data
- valid_out  out  1  data_out valid this cycle
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count <= umbral_L
- almost_full  out  1  count >= umbral_H
- error  out  1  sticky overflow/underflow (see Configuration)

## Operation
- Storage: DEPTH x DATA_WIDTH register array; wr_ptr, rd_ptr ADDR_WIDTH bits, wrap modulo DEPTH naturally; count ADDR_WIDTH+1 bits, range 0..DEPTH.
- push = wr_en & ~full; pop = rd_en & ~empty (both evaluated on registered flags).
- push only: mem[wr_ptr] <= data_in, wr_ptr+1, count+1.
- pop only: data_out <= mem[rd_ptr], valid_out <= 1, rd_ptr+1, count-1.
- push & pop same cycle: both pointers advance, count unchanged; legal at any count 1..DEPTH-1.
- Full: wr_en ignored (data dropped), even if rd_en also high; pop proceeds, count -> DEPTH-1.
- Empty: rd_en ignored, valid_out 0, data_out holds last value; simultaneous wr_en pushes, count -> 1.
- Flags are combinational from registered count and umbral_LH; thresholds compared zero-extended to ADDR_WIDTH+1 bits; thresholds > DEPTH simply never (H) / always (L) match.
- Reset mid-operation: contents discarded logically (mem not cleared), pointers/count to 0 next edge; any concurrent wr_en/rd_en ignored.

## Timing
- Reset values: data_out 0, valid_out 0, error 0, empty 1, full 0, almost_empty 1, almost_full = (umbral_H == 0).
- Push at edge N: empty deasserts and count-based flags update after edge N (visible cycle N+1).
- Read latency 1: rd_en sampled at edge N -> data_out/valid_out valid cycle N+1; valid_out is a single-cycle pulse per pop.
- Back-to-back pops every cycle allowed; first-word fall-through not supported.
- Threshold change takes effect combinationally the same cycle.

## Configuration
- FIFO_ERROR_EN defined: error set on wr_en & full (overflow) or rd_en & empty (underflow), sticky until reset; the offending request is still dropped.
- FIFO_ERROR_EN undefined: error tied 0; drop behaviour unchanged.

## Test plan
- Reset, umbral_LH=8'h62 (L=2,H=6) -> empty=1, almost_empty=1, almost_full=0, valid_out=0, error=0.
- Push 6 words 0x01..0x06 -> almost_empty drops after 3rd push, almost_full rises after 6th, empty=0, full=0.
- Push 2 more (count 8) then push 0x3F -> full=1, 0x3F dropped, error=1 with FIFO_ERROR_EN, 0 without; 8 pops return 0x01..0x06,0x07,0x08 one cycle after each rd_en.
- Count=4, wr_en&rd_en together 5 cycles -> count stays 4, data order preserved across pointer wrap.
- Empty, rd_en=1 with wr_en=1 data 0x15 -> no valid_out, count=1; next rd_en -> data_out=0x15, valid_out pulse, empty=1.
- Count=5, assert reset one cycle with wr_en=1 -> empty=1, count 0, subsequent pop of pushed word 0x2A returns 0x2A.
